// File: rtl/demux_slot_scheduler_if.sv
// demux_slot_scheduler_if: serial beat valid/ready handshake into the slot scheduler
interface demux_slot_scheduler_if;
  logic in_valid;
  logic in_data;
  logic in_ready;
  modport master(output in_valid, output in_data, input in_ready);
  modport slave(input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/demux_slot_scheduler.sv
// demux_slot_scheduler: round-robin time-division slot sequencer for the 16-way demux (DEMUX_SCHED_SKIP_DISABLED_EN skips disabled channels)
module demux_slot_scheduler #(
  parameter int DWELL_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       stop,
  input  logic [15:0]                chan_en_16,
  input  logic [DWELL_W-1:0]         dwell_len,
  demux_slot_scheduler_if.slave      rx,
  output logic [3:0]                 select_4,
  output logic                       data_in_16,
  output logic [15:0]                out_strobe_16,
  output logic                       frame_start,
  output logic                       busy
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;
  logic [3:0] cur_ch, nxt_ch, first_ch;
  logic [DWELL_W-1:0] bit_cnt, dwell_eff, dwell_new;
  logic stop_pend, first_beat;
  logic accept, slot_end, wrap, mask_zero, go_run, go_idle;
  logic [15:0] strobe_nxt;
  assign rx.in_ready = state == RUN;
  assign busy = state == RUN;
  assign accept = rx.in_ready && rx.in_valid;
  assign slot_end = accept && bit_cnt == dwell_eff - DWELL_W'(1);
  assign mask_zero = chan_en_16 == 16'h0;
  assign dwell_new = dwell_len == '0 ? DWELL_W'(1) : dwell_len;
`ifdef DEMUX_SCHED_SKIP_DISABLED_EN
  assign strobe_nxt = 16'h1 << cur_ch;
  // next enabled channel strictly above cur_ch with wrap, and lowest enabled for start
  always_comb begin
    nxt_ch = cur_ch;
    first_ch = 4'd0;
    for (int i = 16; i >= 1; i--)
      if (chan_en_16[4'(cur_ch + 4'(i))]) nxt_ch = 4'(cur_ch + 4'(i));
    for (int i = 15; i >= 0; i--)
      if (chan_en_16[i]) first_ch = 4'(i);
  end
  assign wrap = nxt_ch <= cur_ch;
`else
  assign strobe_nxt = chan_en_16[cur_ch] ? 16'h1 << cur_ch : 16'h0;
  assign nxt_ch = cur_ch + 4'd1;
  assign first_ch = 4'd0;
  assign wrap = cur_ch == 4'd15;
`endif
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // next state: start leaves IDLE when a channel is enabled, stop or an empty mask ends RUN at a slot end
  always_comb begin
    state_nxt = state;
    go_run = 1'b0;
    go_idle = 1'b0;
    if (state == IDLE) begin
      go_run = start && !mask_zero;
      state_nxt = go_run ? RUN : IDLE;
    end else begin
      go_idle = slot_end && (stop_pend || stop || mask_zero);
      state_nxt = go_idle ? IDLE : RUN;
    end
  end
  // slot counters, channel pointer and registered demux outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur_ch <= 4'd0;
      bit_cnt <= '0;
      dwell_eff <= '0;
      stop_pend <= 1'b0;
      first_beat <= 1'b0;
      select_4 <= 4'd0;
      data_in_16 <= 1'b0;
      out_strobe_16 <= 16'h0;
      frame_start <= 1'b0;
    end else begin
      out_strobe_16 <= 16'h0;
      frame_start <= 1'b0;
      if (go_run) begin
        cur_ch <= first_ch;
        bit_cnt <= '0;
        dwell_eff <= dwell_new;
        first_beat <= 1'b1;
        stop_pend <= 1'b0;
      end
      if (state == RUN && stop) stop_pend <= 1'b1;
      if (accept) begin
        data_in_16 <= rx.in_data;
        select_4 <= cur_ch;
        out_strobe_16 <= strobe_nxt;
        frame_start <= first_beat;
        first_beat <= 1'b0;
        bit_cnt <= bit_cnt + DWELL_W'(1);
      end
      if (slot_end) begin
        bit_cnt <= '0;
        cur_ch <= nxt_ch;
        if (wrap) begin
          first_beat <= 1'b1;
          dwell_eff <= dwell_new;
        end
      end
      if (go_idle) stop_pend <= 1'b0;
    end
endmodule

// File: tb/tb_demux_slot_scheduler.sv
// tb_demux_slot_scheduler: table-driven directed check of the slot scheduler
module tb_demux_slot_scheduler;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0;
  logic [15:0] chan_en_16 = 16'h0;
  logic [3:0] dwell_len = 4'd0;
  logic [3:0] select_4;
  logic data_in_16, frame_start, busy;
  logic [15:0] out_strobe_16;
  demux_slot_scheduler_if bus();
  demux_slot_scheduler #(.DWELL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .chan_en_16(chan_en_16),
    .dwell_len(dwell_len), .rx(bus.slave), .select_4(select_4), .data_in_16(data_in_16),
    .out_strobe_16(out_strobe_16), .frame_start(frame_start), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic st, sp;
    logic [15:0] m;
    logic [3:0] dw;
    logic v, d;
    logic rdy;
    logic [3:0] sel;
    logic dat;
    logic [15:0] stb;
    logic frm;
  } vec_t;
  vec_t tbl[$];
  int pass = 0, total = 0;
  logic [3:0] ls;
  logic ld;
  task automatic chk(input string nm, input logic rdy, input logic [3:0] sel, input logic dat,
                     input logic [15:0] stb, input logic frm);
    total++;
    if ({bus.in_ready, busy, select_4, data_in_16, out_strobe_16, frame_start} === {rdy, rdy, sel, dat, stb, frm})
      pass++;
    else
      $display("FAIL %s: got rdy=%b busy=%b sel=%0d dat=%b stb=%h frm=%b, want rdy=%b busy=%b sel=%0d dat=%b stb=%h frm=%b",
               nm, bus.in_ready, busy, select_4, data_in_16, out_strobe_16, frame_start, rdy, rdy, sel, dat, stb, frm);
  endtask
  task automatic push(input logic st, input logic sp, input logic [15:0] m, input logic [3:0] dw,
                      input logic v, input logic d, input logic rdy, input logic [15:0] stb, input logic frm);
    vec_t e;
    e.st = st; e.sp = sp; e.m = m; e.dw = dw; e.v = v; e.d = d;
    e.rdy = rdy; e.sel = ls; e.dat = ld; e.stb = stb; e.frm = frm;
    tbl.push_back(e);
  endtask
  task automatic idle(input logic st, input logic sp, input logic [15:0] m, input logic [3:0] dw, input logic rdy);
    push(st, sp, m, dw, 1'b0, 1'b0, rdy, 16'h0, 1'b0);
  endtask
  task automatic beat(input logic [15:0] m, input logic [3:0] dw, input logic sp, input logic [3:0] ch,
                      input logic d, input logic [15:0] stb, input logic frm, input logic rdy);
    ls = ch;
    ld = d;
    push(1'b0, sp, m, dw, 1'b1, d, rdy, stb, frm);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = 1'b0;
    ls = 4'd0;
    ld = 1'b0;
`ifdef DEMUX_SCHED_SKIP_DISABLED_EN
    begin
      logic [3:0] chs [12] = '{4'd1, 4'd1, 4'd4, 4'd4, 4'd9, 4'd9, 4'd1, 4'd1, 4'd4, 4'd4, 4'd9, 4'd9};
      idle(1, 0, 16'h0, 2, 0);
      idle(0, 1, 16'h0212, 2, 0);
      idle(1, 0, 16'h0212, 2, 1);
      for (int i = 0; i < 12; i++) beat(16'h0212, 2, 0, chs[i], i[0], 16'h1 << chs[i], i % 6 == 0, 1);
      idle(0, 1, 16'h0212, 2, 1);
      beat(16'h0212, 2, 0, 1, 1, 16'h0002, 1, 1);
      beat(16'h0212, 2, 0, 1, 0, 16'h0002, 0, 0);
      idle(1, 0, 16'h8001, 0, 1);
      for (int i = 0; i < 4; i++) beat(16'h8001, 0, 0, i[0] ? 4'd15 : 4'd0, ~i[0], i[0] ? 16'h8000 : 16'h0001, ~i[0], 1);
      beat(16'h0, 0, 0, 0, 1, 16'h0001, 1, 0);
      idle(1, 0, 16'h0001, 3, 1);
      beat(16'h0001, 3, 0, 0, 1, 16'h0001, 1, 1);
      beat(16'h0001, 3, 1, 0, 0, 16'h0001, 0, 1);
      beat(16'h0001, 3, 0, 0, 1, 16'h0001, 0, 0);
      push(0, 0, 16'h0001, 3, 1, 0, 0, 16'h0, 0);
      idle(1, 0, 16'h0003, 2, 1);
      beat(16'h0003, 2, 0, 0, 1, 16'h0001, 1, 1);
      beat(16'h0004, 2, 0, 0, 0, 16'h0001, 0, 1);
      beat(16'h0004, 2, 0, 2, 1, 16'h0004, 0, 1);
      beat(16'h0004, 2, 0, 2, 0, 16'h0004, 0, 1);
      beat(16'h0004, 2, 0, 2, 1, 16'h0004, 1, 1);
      beat(16'h0, 2, 0, 2, 0, 16'h0004, 0, 0);
    end
`else
    idle(1, 0, 16'h0, 1, 0);
    idle(0, 1, 16'h0001, 1, 0);
    idle(1, 0, 16'h0001, 1, 1);
    for (int i = 0; i < 16; i++) beat(16'h0001, 1, 0, 4'(i), i % 3 == 0, i == 0 ? 16'h1 : 16'h0, i == 0, 1);
    beat(16'h0001, 1, 0, 0, 1, 16'h0001, 1, 1);
    idle(0, 1, 16'h0001, 1, 1);
    beat(16'h0001, 1, 0, 1, 0, 16'h0, 0, 0);
    idle(1, 0, 16'h8001, 0, 1);
    for (int i = 0; i < 16; i++)
      beat(16'h8001, 0, 0, 4'(i), i[0], i == 0 ? 16'h0001 : i == 15 ? 16'h8000 : 16'h0, i == 0, 1);
    beat(16'h8001, 0, 1, 0, 1, 16'h0001, 1, 0);
    idle(1, 0, 16'h0001, 3, 1);
    beat(16'h0001, 3, 0, 0, 1, 16'h0001, 1, 1);
    beat(16'h0001, 3, 1, 0, 0, 16'h0001, 0, 1);
    beat(16'h0001, 3, 0, 0, 1, 16'h0001, 0, 0);
    push(0, 0, 16'h0001, 3, 1, 0, 0, 16'h0, 0);
    idle(1, 0, 16'h0001, 1, 1);
    beat(16'h0001, 1, 0, 0, 1, 16'h0001, 1, 1);
    beat(16'h0, 1, 0, 1, 0, 16'h0, 0, 0);
`endif
    #3 chk("reset", 0, 0, 0, 16'h0, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].st; stop = tbl[i].sp; chan_en_16 = tbl[i].m; dwell_len = tbl[i].dw;
      bus.in_valid = tbl[i].v; bus.in_data = tbl[i].d;
      @(posedge clk);
      #1 chk($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].sel, tbl[i].dat, tbl[i].stb, tbl[i].frm);
    end
    start = 1'b1; stop = 1'b0; chan_en_16 = 16'h0001; dwell_len = 4'd3; bus.in_valid = 1'b0;
    @(posedge clk);
    #1 chk("rst_start", 1, ls, ld, 16'h0, 0);
    start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 1'b1;
    @(posedge clk);
    #1 chk("rst_beat", 1, 0, 1, 16'h0001, 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", 0, 0, 0, 16'h0, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rst_after", 0, 0, 0, 16'h0, 0);
    @(posedge clk);
    #1 chk("rst_after2", 0, 0, 0, 16'h0, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/demux_slot_scheduler.md
# demux_slot_scheduler

- Time-division slot scheduler that sequences the 16-way output demultiplexer (`demux_1x16_1x8`).
- Accepts a serial bit stream over a valid/ready handshake and hands each bit to the demux data input.
- Drives the demux 4-bit select so that consecutive slots of `dwell_len` bits go to successive enabled channels, round-robin.
- Sits between the serial receive front end and the demux; provides a one-hot per-channel strobe and a frame marker for downstream channel logic.

## Interface
- `DWELL_W`, default 4: width of the slot-length input (bits per slot).
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request to begin scheduling; honoured in IDLE only.
- `stop` input 1: one-cycle request to finish the current slot, then return to IDLE.
- `chan_en_16` input 16: per-channel enable mask.
- `dwell_len` input DWELL_W: bits per slot; 0 treated as 1.
- `in_valid` input 1: serial beat valid.
- `in_data` input 1: serial data bit.
- `in_ready` output 1: scheduler accepts a beat this cycle.
- `select_4` output 4: demux select, registered; channel of the beat on `data_in_16`.
- `data_in_16` output 1: registered data bit to the demux.
- `out_strobe_16` output 16: one-hot, equals 1<<`select_4` for one cycle per accepted beat, else 0.
- `frame_start` output 1: one-cycle pulse with the strobe of the first beat of each frame.
- `busy` output 1: high in RUN.

## Operation
- States: IDLE, RUN. Internal: `cur_ch[3:0]`, `bit_cnt[DWELL_W-1:0]`, `dwell_eff`, `stop_pend`, `first_beat`.
- IDLE: `in_ready`=0, `busy`=0. On `start` with `chan_en_16`≠0: `cur_ch`=lowest enabled channel, `bit_cnt`=0, latch `dwell_eff`=max(`dwell_len`,1), set `first_beat`, enter RUN. `start` with mask 0 is ignored.
- RUN: `in_ready`=1, `busy`=1. Accept = `in_valid`&`in_ready`. On accept: `data_in_16`<=`in_data`, `select_4`<=`cur_ch`, `out_strobe_16`<=1<<`cur_ch`, `frame_start`<=`first_beat`, clear `first_beat`, `bit_cnt`++.
- Slot end = accept with `bit_cnt`==`dwell_eff`-1: `bit_cnt`<=0; `cur_ch`<=next enabled channel strictly above `cur_ch`, searching with wrap through 15→0 against the current `chan_en_16`. If the search wraps (next ≤ `cur_ch`), set `first_beat` and re-latch `dwell_eff` from `dwell_len`.
- Single enabled channel: next = same channel; every slot end is a wrap, so each slot is a frame.
- Mask becomes 0 at a slot end: go to IDLE.
- Mask changes mid-slot: no effect until the slot end.
- `stop` in RUN sets `stop_pend`. At the next slot end, go to IDLE and clear `stop_pend`; the final beat is still delivered.
- `start` in RUN is ignored. `stop` in IDLE is ignored.
- `stop` on the same cycle as a slot end takes effect at that slot end.
- No accept (`in_valid`=0): all counters hold; strobe and `frame_start` 0.

## Timing
- Reset (async assert): state IDLE; `in_ready`, `busy`, `data_in_16`, `out_strobe_16`, `frame_start` all 0; `select_4`=0; internal registers 0.
- Latency: `in_data` accepted in cycle N appears on `data_in_16`/`select_4`/`out_strobe_16` in cycle N+1.
- `select_4` holds its last value between beats.
- `start` accepted in cycle N: `in_ready`=1 in cycle N+1.
- Final slot end in cycle N: `in_ready`=0 from cycle N+1, and the last strobe is in N+1.
- Full throughput: one beat per cycle when `in_valid` is held high; no bubbles at slot or frame boundaries.
- Reset mid-slot: the partial slot is discarded; no strobe follows.

## Configuration
- `DEMUX_SCHED_SKIP_DISABLED_EN` defined: the channel search skips disabled channels (behaviour above).
- Macro undefined: every channel 0..15 receives a slot in order, whether enabled or not.
  - Beats for a disabled channel are accepted and counted.
  - `data_in_16`/`select_4` still update for those beats, but `out_strobe_16` stays 0.
  - Frame wrap is 15→0, and `start` sets `cur_ch`=0.
  - Mask 0 still blocks `start` and terminates at a slot end.

## Test plan
- Reset: `rst_n`=0 mid-RUN, then release → all outputs 0, IDLE, `in_ready`=0 next edge.
- Round-robin with skip: mask 16'h0212, `dwell_len`=2, 12 continuous beats → strobes on ch1,1,4,4,9,9,1,1,4,4,9,9; `frame_start` on beats 1 and 7.
- `dwell_len`=0 with mask 16'h8001 → one beat per slot alternating ch0/ch15; `frame_start` on every ch0 beat.
- `stop` on the 2nd of 3 beats of a slot (`dwell_len`=3) → third beat delivered, then `in_ready`=0 and `busy`=0 the following cycle.
- Mask change 16'h0003→16'h0004 mid-slot on ch0 → ch0 slot completes, next slot ch2; mask→0 at a slot end → IDLE.
- Macro undefined, mask 16'h0001, `dwell_len`=1, 16 beats → only beat 1 strobes (ch0); `select_4` steps 0..15.
